// File: rtl/board_input_conditioner.sv
// Synchronizes and debounces push-buttons (KEY, active-low) and slide switches (SW),
// and keeps sticky key-press events with a registered interrupt. Optional auto-repeat: BOARD_INPUT_REPEAT_EN.
module board_input_conditioner #(
  parameter int NUM_KEYS        = 4,
  parameter int NUM_SW          = 10,
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int CNT_WIDTH       = 20,
  parameter int REPEAT_DELAY    = 25000000,
  parameter int REPEAT_RATE     = 5000000
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic [NUM_KEYS-1:0] key_raw,
  input  logic [NUM_SW-1:0]   sw_raw,
  output logic [NUM_KEYS-1:0] key_state,
  output logic [NUM_SW-1:0]   sw_state,
  output logic [NUM_KEYS-1:0] key_pending,
  input  logic                clear_req,
  input  logic [NUM_KEYS-1:0] clear_mask,
  output logic                irq
);

  localparam logic [CNT_WIDTH-1:0] DB_LAST = CNT_WIDTH'(DEBOUNCE_CYCLES - 1);

  if (DEBOUNCE_CYCLES < 2 || CNT_WIDTH < $clog2(DEBOUNCE_CYCLES) ||
      REPEAT_DELAY < 1 || REPEAT_RATE < 1) begin : g_bad_cfg
    $error("board_input_conditioner: invalid debounce/repeat parameters");
  end

  // Two-flop synchronizers; keys idle released (high), switches idle low.
  logic [NUM_KEYS-1:0] key_meta, key_sync;
  logic [NUM_SW-1:0]   sw_meta,  sw_sync;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      key_meta <= '1;
      key_sync <= '1;
      sw_meta  <= '0;
      sw_sync  <= '0;
    end else begin
      key_meta <= key_raw;
      key_sync <= key_meta;
      sw_meta  <= sw_raw;
      sw_sync  <= sw_meta;
    end
  end

  logic [NUM_KEYS-1:0] key_acc;   // accepted raw key level (0 = pressed)
  logic [NUM_KEYS-1:0] key_set;   // pending set requests this cycle
  logic [NUM_SW-1:0]   sw_acc;

  for (genvar g = 0; g < NUM_KEYS; g++) begin : g_key
    logic [CNT_WIDTH-1:0] cnt;
    logic                 acc;
    logic                 accept;
    logic                 press;

    assign accept = (key_sync[g] != acc) && (cnt == DB_LAST);
    assign press  = accept && acc;

    always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
        cnt <= '0;
        acc <= 1'b1;
      end else if (key_sync[g] == acc) begin
        cnt <= '0;
      end else if (cnt == DB_LAST) begin
        acc <= key_sync[g];
        cnt <= '0;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end

    assign key_acc[g] = acc;

`ifdef BOARD_INPUT_REPEAT_EN
    localparam int RPT_MAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
    localparam int RPT_W   = (RPT_MAX > 2) ? $clog2(RPT_MAX) : 1;
    localparam logic [RPT_W-1:0] DELAY_LAST = RPT_W'(REPEAT_DELAY - 1);
    localparam logic [RPT_W-1:0] RATE_LAST  = RPT_W'(REPEAT_RATE - 1);

    logic [RPT_W-1:0] rpt_cnt;
    logic             rpt_first_done;
    logic             release_now;
    logic             rpt_hit;

    // A repeat never fires on the edge that accepts the release.
    assign release_now = accept && !acc;
    assign rpt_hit     = !acc && !release_now &&
                         (rpt_first_done ? (rpt_cnt == RATE_LAST) : (rpt_cnt == DELAY_LAST));

    always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
        rpt_cnt        <= '0;
        rpt_first_done <= 1'b0;
      end else if (acc || release_now) begin
        rpt_cnt        <= '0;
        rpt_first_done <= 1'b0;
      end else if (rpt_hit) begin
        rpt_cnt        <= '0;
        rpt_first_done <= 1'b1;
      end else begin
        rpt_cnt <= rpt_cnt + 1'b1;
      end
    end

    assign key_set[g] = press || rpt_hit;
`else
    assign key_set[g] = press;
`endif
  end

  for (genvar g = 0; g < NUM_SW; g++) begin : g_sw
    logic [CNT_WIDTH-1:0] cnt;
    logic                 acc;

    always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
        cnt <= '0;
        acc <= 1'b0;
      end else if (sw_sync[g] == acc) begin
        cnt <= '0;
      end else if (cnt == DB_LAST) begin
        acc <= sw_sync[g];
        cnt <= '0;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end

    assign sw_acc[g] = acc;
  end

  assign key_state = ~key_acc;
  assign sw_state  = sw_acc;

  // clear_req is a single-cycle strobe with no handshake: clear_mask is only
  // looked at while clear_req = 1, and a set in the same cycle beats the clear.
  logic [NUM_KEYS-1:0] clr_vec;
  logic [NUM_KEYS-1:0] pending_next;

  always_comb begin
    clr_vec      = clear_req ? clear_mask : '0;
    pending_next = (key_pending & ~clr_vec) | key_set;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      key_pending <= '0;
      irq         <= 1'b0;
    end else begin
      key_pending <= pending_next;
      irq         <= |pending_next;
    end
  end

endmodule

// File: tb/tb_board_input_conditioner.sv
// Self-checking bench for board_input_conditioner: directed scenarios plus random
// stimulus checked against a sliding-window debounce model.
module tb_board_input_conditioner;
  localparam int NK = 4;
  localparam int NS = 10;
  localparam int DB = 8;
  localparam int RD = 20;
  localparam int RR = 6;
  localparam int OW = 2 * NK + NS + 1;

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic [NK-1:0] key_raw = '1;
  logic [NS-1:0] sw_raw = '0;
  logic          clear_req = 1'b0;
  logic [NK-1:0] clear_mask = '0;
  logic [NK-1:0] key_state, key_pending;
  logic [NS-1:0] sw_state;
  logic          irq;

  always #5 clk = ~clk;

  board_input_conditioner #(
    .NUM_KEYS(NK), .NUM_SW(NS), .DEBOUNCE_CYCLES(DB), .CNT_WIDTH(4),
    .REPEAT_DELAY(RD), .REPEAT_RATE(RR)
  ) dut (
    .clk(clk), .reset_n(reset_n), .key_raw(key_raw), .sw_raw(sw_raw),
    .key_state(key_state), .sw_state(sw_state), .key_pending(key_pending),
    .clear_req(clear_req), .clear_mask(clear_mask), .irq(irq)
  );

  int vectors = 0;
  int errors  = 0;

  // Reference model: a level is accepted once the raw samples taken
  // 2..DB+1 edges ago all disagree with the currently accepted level.
  logic [NK-1:0] m_kacc = '1;
  logic [NK-1:0] m_pend = '0;
  logic [NS-1:0] m_sacc = '0;
  logic          m_irq = 1'b0;
  logic [NK-1:0] kh[$];
  logic [NS-1:0] sh[$];
  int            edge_n = 0;
`ifdef BOARD_INPUT_REPEAT_EN
  int            press_t[NK];
`endif

  initial begin : model
    forever begin
      @(posedge clk or negedge reset_n);
      if (!reset_n) begin
        m_kacc = '1; m_sacc = '0; m_pend = '0; m_irq = 1'b0; edge_n = 0;
        kh.delete(); sh.delete();
        for (int j = 0; j < DB + 2; j++) begin kh.push_back('1); sh.push_back('0); end
      end else begin
        logic [NK-1:0] kflip, set_v, clr_v;
        logic [NS-1:0] sflip;
        edge_n++;
        kh.push_back(key_raw); sh.push_back(sw_raw);
        void'(kh.pop_front()); void'(sh.pop_front());
        kflip = '1; sflip = '1;
        for (int j = 0; j < DB; j++) begin
          kflip &= (kh[j] ^ m_kacc);
          sflip &= (sh[j] ^ m_sacc);
        end
        set_v = kflip & m_kacc;
`ifdef BOARD_INPUT_REPEAT_EN
        for (int i = 0; i < NK; i++) begin
          int el;
          el = edge_n - press_t[i];
          if (!m_kacc[i] && !kflip[i] && (el == RD || (el > RD && (el - RD) % RR == 0)))
            set_v[i] = 1'b1;
          if (kflip[i] && m_kacc[i]) press_t[i] = edge_n;
        end
`endif
        clr_v  = clear_req ? clear_mask : '0;
        m_pend = (m_pend & ~clr_v) | set_v;
        m_irq  = |m_pend;
        m_kacc = m_kacc ^ kflip;
        m_sacc = m_sacc ^ sflip;
      end
    end
  end

  function automatic logic [OW-1:0] exp_vec();
    return {~m_kacc, m_sacc, m_pend, m_irq};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset_n = 1'b0; key_raw = '1; sw_raw = '0; clear_req = 1'b0; clear_mask = '0;
    repeat (3) tick();
    vectors++;
    if ({key_state, sw_state, key_pending, irq} !== '0) begin
      errors++; $display("FAIL reset_during got=%h want=0", {key_state, sw_state, key_pending, irq});
    end
    reset_n = 1'b1;
    for (int n = 1; n <= 12; n++) begin
      tick();
      vectors++;
      if ({key_state, sw_state, key_pending, irq} !== '0 ||
          {key_state, sw_state, key_pending, irq} !== exp_vec()) begin
        errors++; $display("FAIL reset_after n=%0d got=%h want=0", n, {key_state, sw_state, key_pending, irq});
      end
    end
  endtask

  task automatic test_press_release();
    key_raw[0] = 1'b0;
    for (int n = 1; n <= 12; n++) begin
      logic e;
      tick();
      e = (n >= 10);
      vectors++;
      if (key_state[0] !== e || key_pending[0] !== e || irq !== e) begin
        errors++; $display("FAIL press_edge n=%0d got ks=%b kp=%b irq=%b want=%b", n, key_state[0], key_pending[0], irq, e);
      end
    end
    key_raw[0] = 1'b1;
    for (int n = 1; n <= 12; n++) begin
      tick();
      vectors++;
      if (key_state[0] !== (n < 10) || key_pending[0] !== 1'b1 ||
          {key_state, sw_state, key_pending, irq} !== exp_vec()) begin
        errors++; $display("FAIL release_edge n=%0d got ks=%b kp=%b want ks=%b kp=1", n, key_state[0], key_pending[0], n < 10);
      end
    end
  endtask

  task automatic test_glitch();
    int lens[3] = '{5, 7, 8};
    for (int k = 0; k < 3; k++) begin
      key_raw[1] = 1'b0;
      for (int n = 1; n <= 22; n++) begin
        logic e;
        if (n == lens[k] + 1) key_raw[1] = 1'b1;
        tick();
        e = (lens[k] >= DB) && (n >= 10) && (n < 10 + lens[k]);
        vectors++;
        if (key_state[1] !== e || key_pending[1] !== (lens[k] >= DB && n >= 10) ||
            {key_state, sw_state, key_pending, irq} !== exp_vec()) begin
          errors++; $display("FAIL glitch len=%0d n=%0d got ks=%b kp=%b want ks=%b", lens[k], n, key_state[1], key_pending[1], e);
        end
      end
    end
  endtask

  task automatic test_clear();
    clear_req = 1'b0; clear_mask = '1;
    tick();
    vectors++;
    if (key_pending !== 4'b0011 || irq !== 1'b1) begin
      errors++; $display("FAIL clear_ignored got=%b irq=%b want=0011 irq=1", key_pending, irq);
    end
    clear_req = 1'b1; clear_mask = 4'b0001;
    tick();
    vectors++;
    if (key_pending !== 4'b0010 || irq !== 1'b1) begin
      errors++; $display("FAIL clear_bit0 got=%b irq=%b want=0010 irq=1", key_pending, irq);
    end
    clear_mask = 4'b0010;
    tick();
    vectors++;
    if (key_pending !== 4'b0000 || irq !== 1'b0) begin
      errors++; $display("FAIL clear_bit1 got=%b irq=%b want=0000 irq=0", key_pending, irq);
    end
    clear_req = 1'b0; clear_mask = '0;
  endtask

  task automatic test_collision();
    key_raw[2] = 1'b0;
    repeat (9) tick();
    clear_req = 1'b1; clear_mask = 4'b0100;
    tick();
    clear_req = 1'b0; clear_mask = '0;
    vectors++;
    if (key_pending[2] !== 1'b1 || irq !== 1'b1 || key_state[2] !== 1'b1) begin
      errors++; $display("FAIL set_beats_clear got kp=%b irq=%b ks=%b want 1/1/1", key_pending[2], irq, key_state[2]);
    end
    key_raw[2] = 1'b1;
    repeat (12) tick();
    clear_req = 1'b1; clear_mask = '1;
    tick();
    clear_req = 1'b0; clear_mask = '0;
    vectors++;
    if ({key_state, sw_state, key_pending, irq} !== '0) begin
      errors++; $display("FAIL collision_cleanup got=%h want=0", {key_state, sw_state, key_pending, irq});
    end
  endtask

  task automatic test_reset_release_levels();
    key_raw[3] = 1'b0;
    repeat (6) tick();
    reset_n = 1'b0; sw_raw = 10'h2a5;
    repeat (2) tick();
    vectors++;
    if ({key_state, sw_state, key_pending, irq} !== '0) begin
      errors++; $display("FAIL midcount_reset got=%h want=0", {key_state, sw_state, key_pending, irq});
    end
    reset_n = 1'b1;
    for (int n = 1; n <= 12; n++) begin
      logic e;
      tick();
      e = (n >= 10);
      vectors++;
      if (sw_state !== (e ? 10'h2a5 : 10'h000) || key_state !== (e ? 4'b1000 : 4'b0000) ||
          key_pending !== (e ? 4'b1000 : 4'b0000) || irq !== e) begin
        errors++; $display("FAIL release_levels n=%0d got sw=%h ks=%b kp=%b irq=%b", n, sw_state, key_state, key_pending, irq);
      end
    end
    key_raw = '1; sw_raw = '0;
    repeat (12) tick();
    clear_req = 1'b1; clear_mask = '1;
    tick();
    clear_req = 1'b0; clear_mask = '0;
  endtask

  task automatic test_random();
    for (int c = 0; c < 1500; c++) begin
      int kb, sb;
      kb = $urandom_range(0, NK - 1);
      sb = $urandom_range(0, NS - 1);
      if ($urandom_range(0, 5) == 0) key_raw[kb] = ~key_raw[kb];
      if ($urandom_range(0, 5) == 0) sw_raw[sb] = ~sw_raw[sb];
      clear_req  = ($urandom_range(0, 7) == 0);
      clear_mask = NK'($urandom);
      tick();
      vectors++;
      if ({key_state, sw_state, key_pending, irq} !== exp_vec()) begin
        errors++; $display("FAIL random c=%0d got=%h want=%h", c, {key_state, sw_state, key_pending, irq}, exp_vec());
      end
    end
    key_raw = '1; clear_req = 1'b0; clear_mask = '0;
    for (int n = 0; n < 12; n++) begin
      tick();
      vectors++;
      if ({key_state, sw_state, key_pending, irq} !== exp_vec()) begin
        errors++; $display("FAIL random_settle n=%0d got=%h want=%h", n, {key_state, sw_state, key_pending, irq}, exp_vec());
      end
    end
  endtask

`ifdef BOARD_INPUT_REPEAT_EN
  task automatic test_repeat();
    reset_n = 1'b0; key_raw = '1; sw_raw = '0; clear_req = 1'b0; clear_mask = '0;
    repeat (2) tick();
    reset_n = 1'b1;
    tick();
    key_raw[3] = 1'b0;
    for (int n = 1; n <= 70; n++) begin
      logic e;
      if (n == 51) key_raw[3] = 1'b1;
      tick();
      e = (n == 10) || (n >= 30 && n <= 58 && (n - 30) % RR == 0);
      vectors++;
      if (key_pending[3] !== e || {key_state, sw_state, key_pending, irq} !== exp_vec()) begin
        errors++; $display("FAIL repeat n=%0d got kp=%b want=%b", n, key_pending[3], e);
      end
      clear_req  = key_pending[3];
      clear_mask = 4'b1000;
    end
    clear_req = 1'b0; clear_mask = '0;
  endtask
`endif

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    test_reset();
    test_press_release();
    test_glitch();
    test_clear();
    test_collision();
    test_reset_release_levels();
    test_random();
`ifdef BOARD_INPUT_REPEAT_EN
    test_repeat();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
